time_set_ctrl: RTL

Time-entry controller that drives the clock's load interface. It accepts six BCD digits (HH MM SS) over a valid/ready stream and range-checks each digit on arrival. It converts the completed entry to binary and presents it as the packed 17-bit `time_in` word, then asserts the `time_ow` overwrite strobe. It sits between the keypad/UART digit source and the digital clock core.

---
 rtl/time_set_pkg.sv | 41 ++++
 rtl/time_set_ctrl_bcd_pair_to_bin.sv | 17 +
 rtl/time_set_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/time_set_pkg.sv
// Shared types, field widths and digit range limits for the time-entry controller.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        POS_H10 = 3'd0,
        POS_H1  = 3'd1,
        POS_M10 = 3'd2,
        POS_M1  = 3'd3,
        POS_S10 = 3'd4,
        POS_S1  = 3'd5
    } pos_e;

    localparam int HOUR_W     = 5;
    localparam int MIN_W      = 6;
    localparam int SEC_W      = 6;
    localparam int TIME_W     = 17;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;
    localparam int H10_MAX    = 2;
    localparam int MS10_MAX   = 5;

    // Every limit is at most 9, so codes 10..15 fail the comparison at any position.
    function automatic logic digit_ok(input pos_e pos, input logic [3:0] d, input logic [3:0] h10);
        logic [3:0] lim;
        case (pos)
            POS_H10:          lim = 4'(H10_MAX);
            POS_H1:           lim = (h10 == 4'(H10_MAX)) ? 4'(HOUR_MAX % 10) : 4'd9;
            POS_M10, POS_S10: lim = 4'(MS10_MAX);
            default:          lim = 4'd9;
        endcase
        return (d <= lim);
    endfunction

endpackage

// File: rtl/time_set_ctrl_bcd_pair_to_bin.sv
// Combinational tens/ones BCD digit pair to binary conversion, sized to the output field.
module bcd_pair_to_bin #(
    parameter int OUT_W = 6
) (
    input  logic [3:0]       tens_i,
    input  logic [3:0]       ones_i,
    output logic [OUT_W-1:0] bin_o
);

    logic [OUT_W-1:0] tens_w;
    logic [OUT_W-1:0] ones_w;

    assign tens_w = OUT_W'(tens_i);
    assign ones_w = OUT_W'(ones_i);
    assign bin_o  = (tens_w << 3) + (tens_w << 1) + ones_w;

endmodule

// File: rtl/time_set_ctrl.sv
// Six-digit HH MM SS entry controller driving the clock core load interface.
// Optional inactivity timeout in ENTRY is enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int OW_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              digit_valid,
    input  logic [3:0]        digit,
    output logic              digit_ready,
    input  logic              cancel,
    output logic [2:0]        digit_idx,
    output logic              entry_active,
    output logic              digit_err,
    output logic              abort,
    output logic [TIME_W-1:0] time_in,
    output logic              time_ow
);

    state_e            state_q, state_d;
    logic [2:0]        idx_q;
    logic [3:0]        h10_q, h1_q, m10_q, m1_q, s10_q;
    logic [TIME_W-1:0] time_q;
    logic [7:0]        ow_cnt_q;
    logic              err_q, abort_q;

    logic              xfer, cancel_hit, tmo_hit, dig_ok, accept, reject, ow_last, last_digit;
    logic [HOUR_W-1:0] hour_bin;
    logic [MIN_W-1:0]  min_bin;
    logic [SEC_W-1:0]  sec_bin;

    assign xfer       = digit_valid && (state_q != ST_LOAD);
    assign cancel_hit = cancel && (state_q == ST_ENTRY);
    assign dig_ok     = digit_ok(pos_e'(idx_q), digit, h10_q);
    assign accept     = xfer && !cancel_hit && !tmo_hit && dig_ok;
    assign reject     = xfer && !cancel_hit && !tmo_hit && !dig_ok;
    assign last_digit = (idx_q == 3'(POS_S1));
    assign ow_last    = (ow_cnt_q == 8'(OW_CYCLES - 1));

`ifdef TIME_SET_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_q;

    assign tmo_hit = (state_q == ST_ENTRY) && (tmo_cnt_q == TMO_LAST);

    // Any offered digit, accepted or not, counts as activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt_q <= '0;
        else if ((state_q != ST_ENTRY) || digit_valid || tmo_hit)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // The seconds ones digit is never stored; it feeds the converter on its accept edge.
    bcd_pair_to_bin #(.OUT_W(HOUR_W)) u_hour (.tens_i(h10_q), .ones_i(h1_q),  .bin_o(hour_bin));
    bcd_pair_to_bin #(.OUT_W(MIN_W))  u_min  (.tens_i(m10_q), .ones_i(m1_q),  .bin_o(min_bin));
    bcd_pair_to_bin #(.OUT_W(SEC_W))  u_sec  (.tens_i(s10_q), .ones_i(digit), .bin_o(sec_bin));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ENTRY;
            ST_ENTRY: begin
                if (cancel_hit || tmo_hit)
                    state_d = ST_IDLE;
                else if (accept && last_digit)
                    state_d = ST_LOAD;
            end
            ST_LOAD:  if (ow_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        digit_ready  = (state_q != ST_LOAD);
        entry_active = (state_q != ST_IDLE);
        time_ow      = (state_q == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            h10_q    <= '0;
            h1_q     <= '0;
            m10_q    <= '0;
            m1_q     <= '0;
            s10_q    <= '0;
            time_q   <= '0;
            ow_cnt_q <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            err_q    <= reject;
            abort_q  <= cancel_hit || tmo_hit;
            ow_cnt_q <= (state_q == ST_LOAD) ? ow_cnt_q + 8'd1 : 8'd0;
            if (((state_q == ST_LOAD) && ow_last) || cancel_hit || tmo_hit)
                idx_q <= '0;
            else if (accept && !last_digit)
                idx_q <= idx_q + 3'd1;
            if (accept) begin
                case (pos_e'(idx_q))
                    POS_H10: h10_q <= digit;
                    POS_H1:  h1_q  <= digit;
                    POS_M10: m10_q <= digit;
                    POS_M1:  m1_q  <= digit;
                    POS_S10: s10_q <= digit;
                    default: time_q <= {hour_bin, min_bin, sec_bin};
                endcase
            end
        end
    end

    assign digit_idx = idx_q;
    assign digit_err = err_q;
    assign abort     = abort_q;
    assign time_in   = time_q;

endmodule
